// File: rtl/iterative_shifter.sv
// ----------------------------------------------------------------------------
// iterative_shifter
//
// Multi-cycle shift engine for WIDTH-bit words. A request is captured in IDLE,
// then the word is shifted by at most STEP bits per enabled cycle until the
// remaining distance is used up. Supports SLL, SRL, SRA and (optionally) ROL.
//
// Optional feature macro: ITERATIVE_SHIFTER_ROTATE_EN
//   defined   : op=11 rotates left.
//   undefined : no rotate datapath; op=11 behaves exactly as SLL.
//
// Parameters:
//   WIDTH  data width (>= 2)
//   STEP   maximum bits shifted per cycle (1..WIDTH-1)
//   AW     derived, width of the amount field ($clog2(WIDTH))
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   request, sampled only in IDLE
//   ena     in   progress enable, holds everything in BUSY when low
//   op      in   00 SLL, 01 SRL, 10 SRA, 11 ROL
//   amount  in   shift distance 0..WIDTH-1
//   data    in   operand
//   q       out  shift register / result (registered)
//   busy    out  high whenever the state is not IDLE
//   done    out  one-cycle pulse, q holds the final result while high
//
// Handshake: start is a request that is accepted on the first rising edge at
// which the engine is IDLE and start=1; busy acts as "not ready" (requests
// made while busy=1 are dropped, never queued); done is a single-cycle
// completion strobe qualifying q.
// ----------------------------------------------------------------------------
module iterative_shifter #(
  parameter int  WIDTH = 64,
  parameter int  STEP  = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ena,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    amount,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]    OP_SLL = 2'b00;
  localparam logic [1:0]    OP_SRL = 2'b01;
  localparam logic [1:0]    OP_SRA = 2'b10;
  localparam logic [AW-1:0] STEP_C = AW'(STEP);

  state_t           state, state_next;
  logic [AW-1:0]    rem, rem_next;
  logic [1:0]       op_r, op_next;
  logic [WIDTH-1:0] q_next;

  // Per-cycle step datapath
  logic [AW-1:0]    step;
  logic [WIDTH-1:0] sll_v, srl_v, sra_v, shifted;

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
  localparam logic [AW:0] WIDTH_C = (AW+1)'(WIDTH);
  logic [WIDTH-1:0] rol_v;
`endif

  always_comb begin
    // Step is min(rem, STEP); rem=0 gives a zero-distance (no-op) step.
    step  = (rem > STEP_C) ? STEP_C : rem;
    sll_v = q << step;
    srl_v = q >> step;
    // Sign bit never changes across steps, so chained SRA equals one big SRA.
    sra_v = $unsigned($signed(q) >>> step);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    // With step=0 the right-hand term shifts by WIDTH and yields zero.
    rol_v = (q << step) | (q >> (WIDTH_C - {1'b0, step}));
`endif
    case (op_r)
      OP_SLL:  shifted = sll_v;
      OP_SRL:  shifted = srl_v;
      OP_SRA:  shifted = sra_v;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      default: shifted = rol_v;
`else
      default: shifted = sll_v;
`endif
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_next = state;
    q_next     = q;
    rem_next   = rem;
    op_next    = op_r;
    case (state)
      IDLE: begin
        if (start) begin
          q_next     = data;
          rem_next   = amount;
          op_next    = op;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (ena) begin
          q_next   = shifted;
          rem_next = rem - step;
          // Last step (covers rem=0): finish on this same edge.
          if (rem <= STEP_C) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q     <= '0;
      rem   <= '0;
      op_r  <= OP_SLL;
    end else begin
      state <= state_next;
      q     <= q_next;
      rem   <= rem_next;
      op_r  <= op_next;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
